// File: rtl/moore_four_eg.sv
// moore_four_eg: Moore detector for a 4-bit serial PATTERN, out high while in DET
module moore_four_eg #(
  parameter logic [3:0] PATTERN = 4'b1010,
  parameter bit         OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  typedef enum logic [2:0] {S0, S1, S2, S3, DET} state_t;
  state_t state, state_nxt;
  // Next state = longest PATTERN prefix that is a suffix of the matched bits followed by b
  function automatic logic [2:0] step(input logic [2:0] k, input logic b);
    logic [2:0] m;
    logic [4:0] seq;
    logic [2:0] r;
    m = (k == 3'd4 && !OVERLAP) ? 3'd0 : k;
    seq = ((5'(PATTERN) >> (3'd4 - m)) << 1) | 5'(b);
    r = 3'd0;
    for (int l = 1; l <= 4; l++)
      if (l <= int'(m) + 1 && (seq & ((5'd1 << l) - 5'd1)) == (5'(PATTERN) >> (4 - l)))
        r = 3'(l);
    return (k > 3'd4) ? 3'd0 : r;
  endfunction
  always_comb state_nxt = state_t'(step(state, in));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S0;
    else state <= state_nxt;
  assign out = (state == DET);
endmodule

// File: tb/tb_moore_four_eg.sv
// tb_moore_four_eg: vector table plus scoreboard over three parameterisations sharing one input stream
module tb_moore_four_eg;
  typedef struct packed {logic rst; logic in; logic [2:0] exp;} vec_t;
  logic clk = 1'b0, rst = 1'b0, in = 1'b0;
  logic out_a, out_b, out_c;
  int compared = 0, mismatched = 0;
  logic [2:0] sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  moore_four_eg u_a (.clk(clk), .rst(rst), .in(in), .out(out_a));
  moore_four_eg #(.PATTERN(4'b1010), .OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .in(in), .out(out_b));
  moore_four_eg #(.PATTERN(4'b1111), .OVERLAP(1'b1)) u_c (.clk(clk), .rst(rst), .in(in), .out(out_c));

  task automatic check(input string name, input logic got, input logic want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic check3(input string tag, input logic [2:0] e);
    check({tag, "_a"}, out_a, e[2]);
    check({tag, "_b"}, out_b, e[1]);
    check({tag, "_c"}, out_c, e[0]);
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [2:0] e;
    @(negedge clk);
    rst = v.rst;
    in = v.in;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check3(tag, e);
  endtask

  function automatic void add(input logic r, input logic i, input logic [2:0] e);
    vecs.push_back(vec_t'{r, i, e});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // exp bits: {default 1010 overlap, 1010 no overlap, 1111 overlap}
    add(0,1,3'b000); add(0,0,3'b000); add(0,1,3'b000); add(0,0,3'b000); add(0,1,3'b000);
    add(1,1,3'b000); add(1,0,3'b000); add(1,1,3'b000); add(1,0,3'b110);
    add(1,1,3'b000); add(1,0,3'b100); add(1,1,3'b000); add(1,0,3'b110); add(1,0,3'b000);
    add(0,0,3'b000);
    add(1,1,3'b000); add(1,1,3'b000); add(1,0,3'b000); add(1,1,3'b000); add(1,0,3'b110);
    add(0,0,3'b000);
    add(1,1,3'b000); add(1,0,3'b000); add(1,0,3'b000); add(1,1,3'b000);
    add(1,0,3'b000); add(1,1,3'b000); add(1,0,3'b110);
    add(0,0,3'b000);
    add(1,1,3'b000); add(1,1,3'b000); add(1,1,3'b000);
    add(1,1,3'b001); add(1,1,3'b001); add(1,1,3'b001); add(1,0,3'b000);
    #1;
    check3("reset_t0", 3'b000);
    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));
    // async reset while in S3, no partial match kept after release
    apply(vec_t'{1'b0, 1'b0, 3'b000}, "pre_s3_rst");
    apply(vec_t'{1'b1, 1'b1, 3'b000}, "s3_1");
    apply(vec_t'{1'b1, 1'b0, 3'b000}, "s3_2");
    apply(vec_t'{1'b1, 1'b1, 3'b000}, "s3_3");
    #2 rst = 1'b0;
    #1 check3("async_s3", 3'b000);
    apply(vec_t'{1'b1, 1'b0, 3'b000}, "after_s3_rel");
    // async reset while in DET clears out without a clock edge
    apply(vec_t'{1'b1, 1'b1, 3'b000}, "det_1");
    apply(vec_t'{1'b1, 1'b0, 3'b000}, "det_2");
    apply(vec_t'{1'b1, 1'b1, 3'b000}, "det_3");
    apply(vec_t'{1'b1, 1'b0, 3'b110}, "det_4");
    #2 rst = 1'b0;
    #1 check3("async_det", 3'b000);
    apply(vec_t'{1'b1, 1'b0, 3'b000}, "after_det_rel");
    check("sb_empty", sb.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
